// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared image geometry, data widths and loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_DRAIN  = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/img_bram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : img_bram_loader
//  Description : Writes one streamed IMG_W x IMG_H frame into the image BRAM,
//                checks its length, then starts the CNN and waits for done.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_bram_loader #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int ADDR_W = cnn_pkg::ADDR_W,
    parameter int DATA_W = cnn_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              cnn_start,
    input  logic              cnn_done,
    input  logic              clear_err,
    output logic              err_short,
    output logic              err_long,
    output logic [7:0]        frame_cnt,
    output logic              busy
);
    import cnn_pkg::*;

    localparam int              c_npix     = IMG_W * IMG_H;
    localparam int              c_cnt_w    = (c_npix > 1) ? $clog2(c_npix) : 1;
    localparam logic [c_cnt_w-1:0] c_last_pix = c_cnt_w'(c_npix - 1);

    loader_state_t      r_state;
    loader_state_t      w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_armed;
    logic               w_armed_nxt;
    logic               w_beat;
    logic               w_at_last;
    logic               w_set_short;
    logic               w_set_long;

    assign s_tready  = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_beat    = s_tvalid & s_tready;
    assign w_at_last = (r_cnt == c_last_pix);
    assign cnn_start = (r_state == S_START);
    assign busy      = (r_state != S_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_armed_nxt = r_armed;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_beat) begin
                    if (!w_at_last) begin
                        if (s_tlast) begin
                            w_set_short = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else if (s_tlast) begin
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_set_long  = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_beat && s_tlast) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_state_nxt = S_START;
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_armed_nxt = 1'b0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done level left over from the previous run must drop first.
                if (!cnn_done) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_we <= w_beat && (r_state == S_LOAD);
            if (w_beat && (r_state == S_LOAD)) begin
                bram_addr  <= ADDR_W'(r_cnt);
                bram_wdata <= s_tdata;
            end
        end
    end

    // An error raised in the same cycle as clear_err takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err_short <= w_set_short | (err_short & ~clear_err);
            err_long  <= w_set_long  | (err_long  & ~clear_err);
            if (r_state == S_START) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_img_bram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_bram_loader
//  Description : Self-checking bench for img_bram_loader (frame-level model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_bram_loader;
    import cnn_pkg::*;

    localparam int NP = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic              cnn_start;
    logic              cnn_done;
    logic              clear_err;
    logic              err_short;
    logic              err_long;
    logic [7:0]        frame_cnt;
    logic              busy;

    img_bram_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .cnn_start  (cnn_start),
        .cnn_done   (cnn_done),
        .clear_err  (clear_err),
        .err_short  (err_short),
        .err_long   (err_long),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed BRAM writes and start pulses, sampled mid-cycle
    logic [ADDR_W+DATA_W-1:0] got_q[$];
    int n_start   = 0;
    int start_cyc = -1;
    always @(negedge clk) begin
        if (bram_we) got_q.push_back({bram_addr, bram_wdata});
        if (cnn_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pixel data the BRAM must end up holding, in address order
    logic [DATA_W-1:0] exp_q[$];
    int last_cyc = -1;

    task automatic send_frame(input int n, input bit gaps, input bit with_last, input int clr_at);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] d;
            bit acc;
            int guard;
            d     = DATA_W'($urandom);
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                int drive_cyc;
                drive_cyc = cyc;
                s_tvalid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_tdata   = d;
                s_tlast   = with_last && (i == n - 1);
                clear_err = s_tvalid && (i == clr_at);
                #3;
                acc = s_tvalid && s_tready;
                if (acc && (i == n - 1)) last_cyc = drive_cyc;
                @(posedge clk); #1;
                guard++;
                if (!acc && guard > 200) begin
                    chk("beat accept timeout", 0, 1);
                    s_tvalid = 1'b0; s_tlast = 1'b0; clear_err = 1'b0;
                    return;
                end
            end
            if (i < NP) exp_q.push_back(d);
        end
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic release_cnn(input string tag);
        repeat (3) @(posedge clk);
        #1;
        cnn_done = 1'b1;
        #3;
        chk({tag, " ready while done sampled"}, 64'(s_tready), 0);
        @(posedge clk); #1;
        cnn_done = 1'b0;
        #3;
        chk({tag, " ready after done"}, 64'(s_tready), 1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int n;
        bit gaps;
        int exp_wr;
        bit exp_start;
        bit exp_es;
        bit exp_el;
        int exp_fc;
    } vec_t;

    vec_t vt[6];

    task automatic run_vec(input vec_t v, input string tag);
        int s_base, g_base, bad, first_bad;
        s_base = n_start;
        g_base = got_q.size();
        send_frame(v.n, v.gaps, 1'b1, -1);
        repeat (8) @(posedge clk);
        #1;
        chk({tag, " start count"}, 64'(n_start - s_base), 64'(v.exp_start));
        if (v.exp_start) chk({tag, " start latency"}, 64'(start_cyc - last_cyc), 2);
        chk({tag, " write count"}, 64'(got_q.size() - g_base), 64'(v.exp_wr));
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && (g_base + i) < got_q.size(); i++) begin
            if (got_q[g_base + i] !== {ADDR_W'(i), exp_q[i]}) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (bad != 0) $display("  first bad write index %0d", first_bad);
        chk({tag, " bad writes"}, 64'(bad), 0);
        chk({tag, " err_short"}, 64'(err_short), 64'(v.exp_es));
        chk({tag, " err_long"}, 64'(err_long), 64'(v.exp_el));
        chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'(v.exp_fc));
        chk({tag, " busy"}, 64'(busy), 64'(v.exp_start));
        if (v.exp_start) release_cnn(tag);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_base, bad;
        rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        cnn_done = 1'b0; clear_err = 1'b0;

        vt[0] = '{NP,     1'b0, NP,  1'b1, 1'b0, 1'b0, 1};
        vt[1] = '{NP,     1'b1, NP,  1'b1, 1'b0, 1'b0, 2};
        vt[2] = '{100,    1'b0, 100, 1'b0, 1'b1, 1'b0, 2};
        vt[3] = '{NP,     1'b1, NP,  1'b1, 1'b1, 1'b0, 3};
        vt[4] = '{NP + 4, 1'b0, NP,  1'b1, 1'b1, 1'b1, 4};
        vt[5] = '{NP,     1'b1, NP,  1'b1, 1'b0, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset bram_we", 64'(bram_we), 0);
        chk("reset bram_addr", 64'(bram_addr), 0);
        chk("reset frame_cnt", 64'(frame_cnt), 0);
        chk("reset errors", 64'({err_short, err_long}), 0);
        chk("reset start/busy", 64'({cnn_start, busy}), 0);
        chk("reset s_tready", 64'(s_tready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Done still high from the previous run must not release the loader
        s_base   = n_start;
        cnn_done = 1'b1;
        send_frame(NP, 1'b0, 1'b1, -1);
        bad = 0;
        repeat (5) begin
            #3; if (s_tready) bad++;
            @(posedge clk); #1;
        end
        cnn_done = 1'b0;
        repeat (50) begin
            #3; if (s_tready) bad++;
            @(posedge clk); #1;
        end
        chk("stale ready cycles", 64'(bad), 0);
        chk("stale start count", 64'(n_start - s_base), 1);
        chk("stale frame_cnt", 64'(frame_cnt), 5);
        cnn_done = 1'b1;
        #3;
        chk("stale ready at done", 64'(s_tready), 0);
        @(posedge clk); #1;
        cnn_done = 1'b0;
        #3;
        chk("stale ready after done", 64'(s_tready), 1);
        @(posedge clk); #1;

        // Reset in the middle of a frame
        s_base = n_start;
        send_frame(2000, 1'b1, 1'b0, -1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("midrst write port", 64'({bram_we, bram_addr, bram_wdata}), 0);
        chk("midrst errors", 64'({err_short, err_long}), 0);
        chk("midrst frame_cnt", 64'(frame_cnt), 0);
        chk("midrst start/busy", 64'({cnn_start, busy}), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst no start", 64'(n_start - s_base), 0);

        // Error set together with clear_err must leave the flag set
        send_frame(3, 1'b0, 1'b1, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("short flag set", 64'(err_short), 1);
        send_frame(5, 1'b0, 1'b1, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("error beats clear", 64'(err_short), 1);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        chk("clear alone", 64'({err_short, err_long}), 0);

        run_vec(vt[5], "vec5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
